// File: rtl/mdio_pkg.sv
// Shared MDIO field widths and access-type encodings used by the controller and its arbiter.
package mdio_pkg;

  localparam int unsigned MDIO_ACCESS_LENGTH  = 2;
  localparam int unsigned MDIO_PHYADDR_LENGTH = 5;
  localparam int unsigned MDIO_DEVTYPE_LENGTH = 5;
  localparam int unsigned MDIO_DATA_LENGTH    = 16;

  typedef enum logic [1:0] {
    ACCESS_ADDRESS  = 2'b00,
    ACCESS_WRITE    = 2'b01,
    ACCESS_READ_INC = 2'b10,
    ACCESS_READ     = 2'b11
  } mdio_access_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to index 0.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/mdio_access_arbiter.sv
// Round-robin arbiter sharing one MDIO controller among NUM_REQ requesters.
// Optional watchdog on the controller handshake is enabled by defining MDIO_ARB_TIMEOUT_EN.
module mdio_access_arbiter
  import mdio_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ACCESS_LENGTH  = MDIO_ACCESS_LENGTH,
  parameter int unsigned PHYADDR_LENGTH = MDIO_PHYADDR_LENGTH,
  parameter int unsigned DEVTYPE_LENGTH = MDIO_DEVTYPE_LENGTH,
  parameter int unsigned DATA_LENGTH    = MDIO_DATA_LENGTH,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*ACCESS_LENGTH-1:0]    req_access_type,
  input  logic [NUM_REQ*DEVTYPE_LENGTH-1:0]   req_dev_type,
  input  logic [NUM_REQ*PHYADDR_LENGTH-1:0]   req_phy_address,
  input  logic [NUM_REQ*DATA_LENGTH-1:0]      req_reg_address,
  input  logic [NUM_REQ*DATA_LENGTH-1:0]      req_write_data,
  output logic [NUM_REQ-1:0]                  req_grant,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic [NUM_REQ-1:0]                  req_error,
  output logic [DATA_LENGTH-1:0]              rsp_read_data,
  output logic                                mst_access_request,
  output logic [ACCESS_LENGTH-1:0]            mst_access_type,
  output logic [DEVTYPE_LENGTH-1:0]           mst_dev_type,
  output logic [PHYADDR_LENGTH-1:0]           mst_phy_address,
  output logic [DATA_LENGTH-1:0]              mst_reg_address,
  output logic [DATA_LENGTH-1:0]              mst_write_data,
  input  logic [DATA_LENGTH-1:0]              mst_read_data,
  input  logic                                mst_access_complete,
  input  logic                                mst_busy,
  output logic                                arb_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_e;

  state_e                    state, state_nxt;
  logic [IDX_W-1:0]          owner, rr_ptr, pick_idx;
  logic [NUM_REQ-1:0]        pick_grant;
  logic [ACCESS_LENGTH-1:0]  sel_access_type;
  logic [DEVTYPE_LENGTH-1:0] sel_dev_type;
  logic [PHYADDR_LENGTH-1:0] sel_phy_address;
  logic [DATA_LENGTH-1:0]    sel_reg_address, sel_write_data;
  logic                      waiting, finish_ok, wd_expired, read_access;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx)
  );

  always_comb begin
    sel_access_type = '0;
    sel_dev_type    = '0;
    sel_phy_address = '0;
    sel_reg_address = '0;
    sel_write_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_access_type = req_access_type[i*ACCESS_LENGTH +: ACCESS_LENGTH];
        sel_dev_type    = req_dev_type[i*DEVTYPE_LENGTH +: DEVTYPE_LENGTH];
        sel_phy_address = req_phy_address[i*PHYADDR_LENGTH +: PHYADDR_LENGTH];
        sel_reg_address = req_reg_address[i*DATA_LENGTH +: DATA_LENGTH];
        sel_write_data  = req_write_data[i*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  assign waiting     = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign finish_ok   = waiting && mst_access_complete;
  assign read_access = (mst_access_type == ACCESS_LENGTH'(ACCESS_READ)) ||
                       (mst_access_type == ACCESS_LENGTH'(ACCESS_READ_INC));

  // A completion seen before mst_busy rises is accepted directly from WAIT_BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|req_valid) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (mst_access_complete || wd_expired) state_nxt = RESPOND;
        else if (mst_busy)                     state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (mst_access_complete || wd_expired) state_nxt = RESPOND;
      RESPOND:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      req_grant       <= '0;
      mst_access_type <= '0;
      mst_dev_type    <= '0;
      mst_phy_address <= '0;
      mst_reg_address <= '0;
      mst_write_data  <= '0;
      rsp_read_data   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req_valid) begin
        owner           <= pick_idx;
        req_grant       <= pick_grant;
        mst_access_type <= sel_access_type;
        mst_dev_type    <= sel_dev_type;
        mst_phy_address <= sel_phy_address;
        mst_reg_address <= sel_reg_address;
        mst_write_data  <= sel_write_data;
      end
      if (finish_ok && read_access) rsp_read_data <= mst_read_data;
      else if (wd_expired)          rsp_read_data <= '1;
      if (state == RESPOND) begin
        req_grant <= '0;
        rr_ptr    <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

  assign mst_access_request = (state == ISSUE);
  assign req_done           = (state == RESPOND) ? req_grant : '0;
  assign arb_busy           = (state != IDLE);

`ifdef MDIO_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_count;
  logic             timed_out;

  // Expires on the TIMEOUT_CYCLES-th waiting cycle; a same-cycle completion wins.
  assign wd_expired = waiting && !mst_access_complete &&
                      (wd_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_count  <= '0;
      timed_out <= 1'b0;
    end else begin
      wd_count <= waiting ? wd_count + 1'b1 : '0;
      if (wd_expired)             timed_out <= 1'b1;
      else if (state == RESPOND)  timed_out <= 1'b0;
    end
  end

  assign req_error = req_done & {NUM_REQ{timed_out}};
`else
  assign wd_expired = 1'b0;
  assign req_error  = '0;
`endif

endmodule

// File: tb/tb_mdio_access_arbiter.sv
// Directed self-checking bench for mdio_access_arbiter with a transaction-level expectation model.
module tb_mdio_access_arbiter;
  import mdio_pkg::*;

  localparam int N = 4;
`ifdef MDIO_ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_valid;
  logic [N*2-1:0]  req_access_type;
  logic [N*5-1:0]  req_dev_type, req_phy_address;
  logic [N*16-1:0] req_reg_address, req_write_data;
  logic [N-1:0]  req_grant, req_done, req_error;
  logic [15:0]   rsp_read_data;
  logic          mst_access_request;
  logic [1:0]    mst_access_type;
  logic [4:0]    mst_dev_type, mst_phy_address;
  logic [15:0]   mst_reg_address, mst_write_data, mst_read_data;
  logic          mst_access_complete, mst_busy, arb_busy;

  mdio_access_arbiter #(
    .NUM_REQ        (N),
    .ACCESS_LENGTH  (2),
    .PHYADDR_LENGTH (5),
    .DEVTYPE_LENGTH (5),
    .DATA_LENGTH    (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_access_type     (req_access_type),
    .req_dev_type        (req_dev_type),
    .req_phy_address     (req_phy_address),
    .req_reg_address     (req_reg_address),
    .req_write_data      (req_write_data),
    .req_grant           (req_grant),
    .req_done            (req_done),
    .req_error           (req_error),
    .rsp_read_data       (rsp_read_data),
    .mst_access_request  (mst_access_request),
    .mst_access_type     (mst_access_type),
    .mst_dev_type        (mst_dev_type),
    .mst_phy_address     (mst_phy_address),
    .mst_reg_address     (mst_reg_address),
    .mst_write_data      (mst_write_data),
    .mst_read_data       (mst_read_data),
    .mst_access_complete (mst_access_complete),
    .mst_busy            (mst_busy),
    .arb_busy            (arb_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // Requester-side copies of each requester's fields, and the expected DUT outputs.
  logic [1:0]  acc_a[N];
  logic [4:0]  dev_a[N], phy_a[N];
  logic [15:0] reg_a[N], wd_a[N];
  logic [N-1:0] exp_grant, exp_done, exp_err;
  logic        exp_req, exp_busy;
  logic [15:0] exp_rsp, exp_reg, exp_wd;
  logic [1:0]  exp_acc;
  logic [4:0]  exp_dev, exp_phy;
  bit          chk_en = 1'b0;
  int          rr_m = 0;

  // Observations (edge numbers are those of the sampling edge).
  int          gq[$];
  int          t_req = 0, t_done = 0, t_cmp = 0, tv = 0, base = 0;
  logic [15:0] req_wd_seen = '0, done_rsp_seen = '0;
  logic [N-1:0] err_seen = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, want);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    int r = -1;
    for (int k = 0; k < N; k++)
      if (g[k]) r = (r == -1) ? k : -2;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mst_access_request) begin
      t_req       = cyc + 1;
      req_wd_seen = mst_write_data;
      gq.push_back(onehot_idx(req_grant));
    end
    if (|req_done) begin
      t_done        = cyc + 1;
      done_rsp_seen = rsp_read_data;
      err_seen      = req_error;
    end
    if (chk_en) begin
      check("grant",    32'(req_grant),          32'(exp_grant));
      check("done",     32'(req_done),           32'(exp_done));
      check("error",    32'(req_error),          32'(exp_err));
      check("request",  32'(mst_access_request), 32'(exp_req));
      check("arb_busy", 32'(arb_busy),           32'(exp_busy));
      check("rsp",      32'(rsp_read_data),      32'(exp_rsp));
      check("mst_acc",  32'(mst_access_type),    32'(exp_acc));
      check("mst_dev",  32'(mst_dev_type),       32'(exp_dev));
      check("mst_phy",  32'(mst_phy_address),    32'(exp_phy));
      check("mst_reg",  32'(mst_reg_address),    32'(exp_reg));
      check("mst_wd",   32'(mst_write_data),     32'(exp_wd));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_exp;
    exp_grant = '0; exp_done = '0; exp_err = '0; exp_req = 1'b0; exp_busy = 1'b0;
    exp_rsp = '0; exp_acc = '0; exp_dev = '0; exp_phy = '0; exp_reg = '0; exp_wd = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [4:0] d, input logic [4:0] p,
                         input logic [15:0] r, input logic [15:0] w);
    acc_a[i] = a; dev_a[i] = d; phy_a[i] = p; reg_a[i] = r; wd_a[i] = w;
    req_access_type[i*2 +: 2]  = a;
    req_dev_type[i*5 +: 5]     = d;
    req_phy_address[i*5 +: 5]  = p;
    req_reg_address[i*16 +: 16] = r;
    req_write_data[i*16 +: 16]  = w;
  endtask

  task automatic issue_exp(input int own);
    exp_grant = N'(1 << own); exp_req = 1'b1; exp_busy = 1'b1;
    exp_acc = acc_a[own]; exp_dev = dev_a[own]; exp_phy = phy_a[own];
    exp_reg = reg_a[own]; exp_wd = wd_a[own];
  endtask

  // Entered with the arbiter in IDLE this cycle and at least one request pending.
  task automatic txn(input int busy_cyc, input logic [15:0] rdata, input bit drop_mid, input bit to_mode);
    int own;
    own = pick(req_valid, rr_m);
    tick;
    issue_exp(own);
    tick;
    exp_req = 1'b0;
    if (to_mode) begin
      repeat (TO - 1) tick;
      tick;
      exp_err = N'(1 << own);
      exp_rsp = 16'hFFFF;
    end else begin
      for (int k = 0; k < busy_cyc; k++) begin
        mst_busy = 1'b1;
        if (drop_mid && k == 1) req_valid[own] = 1'b0;
        tick;
      end
      mst_access_complete = 1'b1;
      mst_read_data       = rdata;
      t_cmp               = cyc;
      tick;
      mst_access_complete = 1'b0;
      mst_busy            = 1'b0;
      mst_read_data       = 16'hDEAD;
      if (acc_a[own] == 2'b10 || acc_a[own] == 2'b11) exp_rsp = rdata;
    end
    exp_done = N'(1 << own);
    tick;
    req_valid[own] = 1'b0;
    rr_m      = (own + 1) % N;
    exp_grant = '0; exp_done = '0; exp_err = '0; exp_busy = 1'b0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick;
    zero_exp();
    rr_m = 0;
    reset_n = 1'b1;
    tick;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int own_r;

  initial begin
    reset_n = 1'b0; req_valid = '0;
    req_access_type = '0; req_dev_type = '0; req_phy_address = '0;
    req_reg_address = '0; req_write_data = '0;
    mst_read_data = '0; mst_access_complete = 1'b0; mst_busy = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 5'd0, 5'd0, 16'h0, 16'h0);
    zero_exp();
    repeat (3) tick;
    chk_en = 1'b1;
    tick;
    check("reset_arb_busy", 32'(arb_busy), 32'd0);
    check("reset_grant",    32'(req_grant), 32'd0);
    reset_n = 1'b1;
    tick;

    // Single write from requester 1
    set_req(1, 2'b01, 5'd3, 5'd1, 16'h0004, 16'hA5A5);
    req_valid[1] = 1'b1;
    tv = cyc;
    txn(2, 16'h0BAD, 1'b0, 1'b0);
    check("wr_req_latency",  32'(t_req - tv), 32'd2);
    check("wr_done_latency", 32'(t_done - t_cmp), 32'd2);
    check("wr_data",         32'(req_wd_seen), 32'hA5A5);
    check("wr_rsp_hold",     32'(rsp_read_data), 32'h0000);

    // Single read from requester 0, completion without busy; pointer wraps 2 -> 0
    set_req(0, 2'b11, 5'd1, 5'd2, 16'h0002, 16'h0000);
    req_valid[0] = 1'b1;
    txn(0, 16'h1234, 1'b0, 1'b0);
    check("rd_data",         32'(done_rsp_seen), 32'h1234);
    check("rd_done_latency", 32'(t_done - t_cmp), 32'd2);
    check("rd_no_error",     32'(err_seen), 32'd0);

    // Address access with a long busy phase leaves the read result untouched
    set_req(2, 2'b00, 5'd4, 5'd5, 16'h0100, 16'h00FF);
    req_valid[2] = 1'b1;
    txn(5, 16'h5555, 1'b0, 1'b0);
    check("addr_rsp_hold", 32'(rsp_read_data), 32'h1234);

    // All four at once from reset; requester 0 re-requests right after its done
    do_reset();
    set_req(0, 2'b11, 5'd1, 5'd0, 16'h0010, 16'h0000);
    set_req(1, 2'b10, 5'd1, 5'd1, 16'h0011, 16'h0000);
    set_req(2, 2'b01, 5'd1, 5'd2, 16'h0012, 16'h1212);
    set_req(3, 2'b11, 5'd1, 5'd3, 16'h0013, 16'h0000);
    req_valid = 4'hF;
    base = gq.size();
    txn(1, 16'hC000, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    txn(2, 16'hC001, 1'b0, 1'b0);
    txn(1, 16'hC002, 1'b0, 1'b0);
    txn(3, 16'hC003, 1'b0, 1'b0);
    txn(1, 16'hC004, 1'b0, 1'b0);
    check("rr_count", 32'(gq.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(gq[base + k]), 32'(exp_order[k]));
    check("rr_last_rsp", 32'(rsp_read_data), 32'hC004);

    // Owner drops req_valid during WAIT_DONE
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    base = gq.size();
    txn(3, 16'h7777, 1'b1, 1'b0);
    check("drop_done_latency", 32'(t_done - t_cmp), 32'd2);
    txn(1, 16'h8888, 1'b0, 1'b0);
    check("drop_first",  32'(gq[base]), 32'd1);
    check("drop_second", 32'(gq[base + 1]), 32'd2);

    // Reset during WAIT_DONE
    set_req(3, 2'b11, 5'd7, 5'd9, 16'h0020, 16'h0000);
    req_valid[3] = 1'b1;
    own_r = pick(req_valid, rr_m);
    tick;
    issue_exp(own_r);
    tick;
    exp_req  = 1'b0;
    mst_busy = 1'b1;
    tick;
    reset_n = 1'b0;
    tick;
    mst_busy  = 1'b0;
    req_valid = '0;
    zero_exp();
    rr_m = 0;
    check("rst_mid_busy", 32'(arb_busy), 32'd0);
    check("rst_mid_done", 32'(req_done), 32'd0);
    tick;
    reset_n = 1'b1;
    tick;

    // Pointer is back at 0 after reset: requester 1 beats requester 3
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    base = gq.size();
    txn(1, 16'h4321, 1'b0, 1'b0);
    txn(1, 16'h9876, 1'b0, 1'b0);
    check("post_rst_first",  32'(gq[base]), 32'd1);
    check("post_rst_second", 32'(gq[base + 1]), 32'd3);

`ifdef MDIO_ARB_TIMEOUT_EN
    // Controller never responds; the watchdog ends the access
    set_req(2, 2'b11, 5'd2, 5'd6, 16'h0030, 16'h0000);
    req_valid[2] = 1'b1;
    txn(0, 16'h0000, 1'b0, 1'b1);
    check("to_rsp",   32'(done_rsp_seen), 32'hFFFF);
    check("to_error", 32'(err_seen), 32'h4);
`endif

    tick;
    tick;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_access_arbiter.md
MDIO_ACCESS_ARBITER -- requirements
Module: mdio_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameters ACCESS_LENGTH=2, PHYADDR_LENGTH=5, DEVTYPE_LENGTH=5, DATA_LENGTH=16: field widths matching the MDIO controller.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit in clk cycles.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request level, held until its req_done.
- req_access_type  in  NUM_REQ*ACCESS_LENGTH  packed; slice i belongs to requester i.
- req_dev_type  in  NUM_REQ*DEVTYPE_LENGTH  packed.
- req_phy_address  in  NUM_REQ*PHYADDR_LENGTH  packed.
- req_reg_address  in  NUM_REQ*DATA_LENGTH  packed.
- req_write_data  in  NUM_REQ*DATA_LENGTH  packed.
- req_grant  out  NUM_REQ  one-hot owner of the current transaction.
- req_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_error  out  NUM_REQ  one-cycle timeout flag, coincident with req_done.
- rsp_read_data  out  DATA_LENGTH  read result, valid while req_done is high.
- mst_access_request  out  1  one-cycle request pulse to the controller.
- mst_access_type, mst_dev_type, mst_phy_address, mst_reg_address, mst_write_data  out  field widths  registered copy of the owner's fields.
- mst_read_data  in  DATA_LENGTH  controller read data.
- mst_access_complete  in  1  controller completion pulse.
- mst_busy  in  1  controller busy.
- arb_busy  out  1  high in every state except IDLE.

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
REQ-006 IDLE: if any req_valid bit is set, choose by round-robin from index rr_ptr upward, with wrap. Register the owner index, req_grant, and the owner's fields into the mst_* outputs. Next state is ISSUE.
REQ-007 ISSUE: mst_access_request=1 for exactly one cycle, then WAIT_BUSY.
REQ-008 WAIT_BUSY: when mst_busy=1, go to WAIT_DONE. If mst_access_complete arrives first, treat it as WAIT_DONE completion.
REQ-009 WAIT_DONE: on mst_access_complete=1, capture mst_read_data into rsp_read_data, then RESPOND.
REQ-010 RESPOND: req_done[owner]=1 for one cycle; rr_ptr = (owner+1) mod NUM_REQ; req_grant cleared at exit; next state IDLE.
REQ-011 mst_* field outputs SHALL stay stable from ISSUE through RESPOND.
REQ-012 Latency from req_valid rise (arbiter in IDLE) to mst_access_request is 2 cycles. Latency from mst_access_complete to req_done is 2 cycles.
REQ-013 A requester drops req_valid at the edge where it samples req_done, so the arbiter sees it low in the following IDLE cycle.
REQ-014 Requesters arriving during a transaction wait. Simultaneous requests are served in strict round-robin order, so no requester waits more than NUM_REQ-1 transactions.
REQ-015 rsp_read_data is undefined for writes but SHALL hold its last captured value.
REQ-016 req_valid deasserted by the owner mid-transaction is ignored; the transaction completes and req_done still pulses.

Reset
REQ-017 With reset_n=0 at an edge: state=IDLE, rr_ptr=0, owner=0, and all outputs 0. This applies mid-transaction; any pending controller access is abandoned.

Configuration
REQ-018 Macro MDIO_ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES, the FSM goes to RESPOND with req_error[owner]=1 and rsp_read_data=16'hFFFF.
- Undefined: no counter; req_error is tied to 0; the arbiter waits indefinitely.

Structure
REQ-019 Shared package mdio_pkg SHALL hold the field-width constants and the access-type encodings (ADDRESS=2'b00, WRITE=2'b01, READ_INC=2'b10, READ=2'b11).
REQ-020 The FSM state typedef SHALL be local to the module.
REQ-021 Sub-module rr_priority_picker SHALL be combinational: inputs req vector and pointer; output one-hot grant and index.

Verification
REQ-022 Single write: req_valid[1]=1, type 2'b01, reg 16'h0004, wdata 16'hA5A5. Required: mst_access_request 2 cycles later with mst_write_data=16'hA5A5; req_done[1] 2 cycles after mst_access_complete.
REQ-023 Single read: requester 0, mst_read_data=16'h1234 at complete. Required: rsp_read_data=16'h1234 with req_done[0].
REQ-024 All four requesters asserted at once from reset. Required: grant order 0,1,2,3. Requester 0 re-requests immediately; it is served after 3.
REQ-025 reset_n=0 during WAIT_DONE. Required: next cycle all outputs 0 and arb_busy=0; no req_done pulse.
REQ-026 MDIO_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, mst_busy never rises. Required: req_done[2] and req_error[2] together, with rsp_read_data=16'hFFFF.
REQ-027 Owner drops req_valid during WAIT_DONE. Required: req_done still pulses, and the next grant goes to the next requester in order.
